instr_fetch_unit: RTL

//  Fetch stage upstream of the main control decoder. Holds the PC, fetches one
//  32-bit word from instruction memory over a req/ready handshake, holds it in an

---
 rtl/instr_fetch_unit.sv | 83 ++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one instruction word per req/ready handshake,
// and computes the next PC from the branch/zero/jump outcome when the datapath retires.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic [5:0]       opcode,
  output logic             instr_valid,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  input  logic             retire,
  input  logic             branch,
  input  logic             zero,
  input  logic             jump,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;

  logic [1:0]  state;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  // Request is decoded from state so an async reset withdraws it immediately.
  assign imem_req   = (state == FETCH);
  assign imem_addr  = pc;
  assign opcode     = instr[31:26];
  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Jump outranks a taken branch; everything wraps modulo 2^32.
  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (branch && zero)
      next_pc = pc_plus4 + branch_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en)
            state <= FETCH;
        end
        FETCH: begin
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (retire) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            retired_cnt <= retired_cnt + CNT_W'(1);
            state       <= en ? FETCH : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
